// File: rtl/accum_diff_decoder.sv
// Difference decoder: turns a stream of running sums back into increments.
// Two-entry output FIFO with valid/ready on both sides and a delivery counter.
module accum_diff_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_sum,
  input  logic             s_clr,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_delta,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] refv;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] delta;
  logic             acc;
  logic             pop;

  assign acc   = s_valid & s_ready;
  assign pop   = m_valid & m_ready;
  assign base  = s_clr ? '0 : refv;
  assign delta = s_sum - base;

  // m_delta is the FIFO head; tail only holds the second entry while FULL
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= EMPTY;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_delta <= '0;
      tail    <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state   <= ONE;
            m_valid <= 1'b1;
            m_delta <= delta;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            state   <= FULL;
            s_ready <= 1'b0;
            tail    <= delta;
          end else if (!acc && pop) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            m_delta <= '0;
          end else if (acc && pop) begin
            m_delta <= delta;
          end
        end
        FULL: begin
          if (pop) begin
            state   <= ONE;
            s_ready <= 1'b1;
            m_delta <= tail;
          end
        end
        default: begin
          state   <= EMPTY;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          m_delta <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      refv <= '0;
    end else if (acc) begin
      refv <= s_sum;
    end else if (s_clr) begin
      refv <= '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (pop && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_accum_diff_decoder.sv
// Bench for accum_diff_decoder: queue model checked every cycle,
// plus directed sequences with literal expected deltas and counts.
module tb_accum_diff_decoder;

  logic       clk;
  logic       clr_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_sum;
  logic       s_clr;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_delta;
  logic [7:0] count;

  int errors;
  int checks;

  accum_diff_decoder #(.WIDTH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sum   (s_sum),
    .s_clr   (s_clr),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_delta (m_delta),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: sums in, differences out through a bounded queue
  logic [3:0] mdl_ref;
  logic [3:0] mdl_q[$];
  int         mdl_cnt;
  logic [3:0] mdl_d;
  bit         mdl_acc;
  bit         mdl_pop;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mdl_ref = 4'd0;
      mdl_q.delete();
      mdl_cnt = 0;
    end else begin
      mdl_acc = s_valid && (mdl_q.size() < 2);
      mdl_pop = (mdl_q.size() > 0) && m_ready;
      mdl_d   = s_sum - (s_clr ? 4'd0 : mdl_ref);
      if (mdl_pop) begin
        void'(mdl_q.pop_front());
        mdl_cnt = (mdl_cnt >= 255) ? 255 : mdl_cnt + 1;
      end
      if (mdl_acc) begin
        mdl_q.push_back(mdl_d);
        mdl_ref = s_sum;
      end else if (s_clr) begin
        mdl_ref = 4'd0;
      end
    end
  end

  // delivered deltas as seen on the DUT port
  int got[$];

  always @(negedge clk) begin
    if (clr_n) begin
      chk("m_valid", int'(m_valid), int'(mdl_q.size() > 0));
      chk("s_ready", int'(s_ready), int'(mdl_q.size() < 2));
      chk("m_delta", int'(m_delta),
          (mdl_q.size() > 0) ? int'(mdl_q[0]) : 0);
      chk("count", int'(count), mdl_cnt);
      if (m_valid && m_ready) got.push_back(int'(m_delta));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    cyc(2);
    clr_n = 1'b1;
    got.delete();
  endtask

  // offer one sum; returns once it has been accepted (bounded)
  task automatic send(input logic [3:0] v, input logic c);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_sum   = v;
    s_clr   = c;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 0, 1);
    s_valid = 1'b0;
    s_clr   = 1'b0;
  endtask

  task automatic chk_got(input string name, input int exp[$]);
    chk({name, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk(name, (i < got.size()) ? got[i] : -1, exp[i]);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    clr_n   = 1'b0;
    s_valid = 1'b0;
    s_sum   = 4'd0;
    s_clr   = 1'b0;
    m_ready = 1'b0;
    cyc(2);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_delta", int'(m_delta), 0);
    chk("rst_count", int'(count), 0);

    // 1: back-to-back sums
    do_reset();
    m_ready = 1'b1;
    send(4'd1, 1'b0);
    chk("t1_lat_valid", int'(m_valid), 1);
    chk("t1_lat_delta", int'(m_delta), 1);
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    send(4'd3, 1'b0);
    cyc(3);
    chk_got("t1_delta", '{1, 1, 1, 0});
    chk("t1_count", int'(count), 4);

    // 2: modulo wrap, then clear without accept
    do_reset();
    m_ready = 1'b1;
    send(4'd14, 1'b0);
    send(4'd3, 1'b0);
    s_clr = 1'b1;
    cyc(1);
    s_clr = 1'b0;
    send(4'd2, 1'b0);
    cyc(3);
    chk_got("t2_delta", '{14, 5, 2});

    // 3: backpressure
    do_reset();
    m_ready = 1'b0;
    send(4'd5, 1'b0);
    send(4'd7, 1'b0);
    s_valid = 1'b1;
    s_sum   = 4'd9;
    cyc(3);
    chk("t3_full_ready", int'(s_ready), 0);
    chk("t3_hold_delta", int'(m_delta), 5);
    m_ready = 1'b1;
    send(4'd9, 1'b0);
    cyc(3);
    chk_got("t3_delta", '{5, 2, 2});
    chk("t3_count", int'(count), 3);

    // 4: clear together with accept, ref becomes the new sum
    got.delete();
    send(4'd6, 1'b1);
    send(4'd7, 1'b0);
    cyc(3);
    chk_got("t4_delta", '{6, 1});

    // 5: async reset while FULL
    m_ready = 1'b0;
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    chk("t5_full", int'(s_ready), 0);
    #2;
    clr_n = 1'b0;
    #1;
    chk("t5_m_valid", int'(m_valid), 0);
    chk("t5_s_ready", int'(s_ready), 1);
    chk("t5_count", int'(count), 0);
    chk("t5_m_delta", int'(m_delta), 0);
    #2;
    clr_n = 1'b1;
    got.delete();
    cyc(1);
    m_ready = 1'b1;
    send(4'd4, 1'b0);
    cyc(2);
    chk_got("t5_delta", '{4});

    // 6: counter saturation
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 300; i++) send(4'(i), 1'b0);
    cyc(3);
    chk("t6_pops", got.size(), 300);
    chk("t6_count", int'(count), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
